obstacle_scheduler: RTL



---
 rtl/obstacle_pkg.sv | 39 +++
 rtl/obstacle_scheduler_lfsr8.sv | 25 ++
 rtl/obstacle_scheduler.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/obstacle_pkg.sv
// rtl/obstacle_pkg.sv - shared obstacle codes, scheduler state encoding and timing constants
package obstacle_pkg;

  typedef logic [2:0] obs_code_t;

  localparam obs_code_t OBS_WALL           = 3'b000;
  localparam obs_code_t OBS_LASER          = 3'b001;
  localparam obs_code_t OBS_PIT            = 3'b010;
  localparam obs_code_t OBS_SWEEPER        = 3'b011;
  localparam obs_code_t OBS_MOUSE_FOLLOWER = 3'b100;
  localparam obs_code_t OBS_NONE           = 3'b111;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GAP    = 2'd1;
  localparam logic [1:0] ST_LAUNCH = 2'd2;
  localparam logic [1:0] ST_RUN    = 2'd3;

  localparam int         NUM_OBSTACLES_DEF  = 5;
  localparam int         CLK_HZ             = 65_000_000;
  localparam int         GAP_CYCLES_DEF     = CLK_HZ;
  localparam int         TIMEOUT_CYCLES_DEF = 20 * CLK_HZ;
  localparam logic [7:0] LFSR_SEED_DEF      = 8'hA5;

  // Folding the raw LFSR bits with a modulo equals a single conditional
  // subtract for four or more obstacles and keeps smaller counts in range.
  function automatic obs_code_t pick_next(input logic [2:0] c0, input obs_code_t last,
                                          input int num);
    obs_code_t c1;
    obs_code_t inc;
    c1  = 3'(int'(c0) % num);
    inc = 3'(int'(c1) + 1);
    if (c1 == last) begin
      pick_next = (int'(c1) + 1 == num) ? 3'd0 : inc;
    end else begin
      pick_next = c1;
    end
  endfunction

endpackage

// File: rtl/obstacle_scheduler_lfsr8.sv
// rtl/obstacle_scheduler_lfsr8.sv - free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1
module lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  assign q_d = {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};

  // An all-zero seed would lock the register, so it is replaced by 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= (seed == 8'h00) ? 8'h01 : seed;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// rtl/obstacle_scheduler.sv - picks, arms and supervises one obstacle at a time with a pause between them
module obstacle_scheduler
  import obstacle_pkg::*;
#(
  parameter int         NUM_OBSTACLES  = NUM_OBSTACLES_DEF,
  parameter int         GAP_CYCLES     = GAP_CYCLES_DEF,
  parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [7:0] LFSR_SEED      = LFSR_SEED_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       menu_on,
  input  logic       start,
  input  logic       player_dead,
  input  logic [7:0] obstacle_done,
  output logic [2:0] selected,
  output logic       play_selected,
  output logic       done_out,
  output logic       busy,
  output logic [7:0] cleared_cnt
);

  localparam logic [26:0] GAP_LAST = 27'(GAP_CYCLES - 1);
  localparam logic [30:0] RUN_LAST = 31'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [26:0] gap_cnt_q, gap_cnt_d;
  logic [30:0] run_cnt_q, run_cnt_d;
  obs_code_t   last_q, last_d;
  obs_code_t   sel_q, sel_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        play_q, done_q, busy_q;

  logic [7:0]  lfsr;
  logic        lfsr_unused;
  obs_code_t   next_code;
  logic        abort;
  logic        sel_done;

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr)
  );

  assign lfsr_unused = ^lfsr[7:3];
  assign next_code   = pick_next(lfsr[2:0], last_q, NUM_OBSTACLES);
  assign abort       = menu_on | player_dead;
  assign sel_done    = obstacle_done[sel_q];

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    run_cnt_d = run_cnt_q;
    last_d    = last_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !menu_on) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
          cnt_d     = '0;
          last_d    = OBS_NONE;
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (gap_cnt_q >= GAP_LAST) begin
          state_d = ST_LAUNCH;
          sel_d   = next_code;
        end else begin
          gap_cnt_d = gap_cnt_q + 27'd1;
        end
      end
      ST_LAUNCH: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_RUN;
          run_cnt_d = '0;
        end
      end
      ST_RUN: begin
        // Abort wins over both completion and the watchdog.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (sel_done) begin
          if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
          end
          last_d    = sel_q;
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end else if (run_cnt_q >= RUN_LAST) begin
          last_d    = sel_q;
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end else begin
          run_cnt_d = run_cnt_q + 31'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state; the arm pulse trails the
  // LAUNCH entry by one edge so selected is already stable when it fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= '0;
      run_cnt_q <= '0;
      last_q    <= OBS_NONE;
      sel_q     <= '0;
      cnt_q     <= '0;
      play_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      run_cnt_q <= run_cnt_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      play_q    <= (state_d == ST_LAUNCH) || (state_d == ST_RUN);
      done_q    <= (state_q == ST_LAUNCH) && (state_d == ST_RUN);
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign selected      = sel_q;
  assign play_selected = play_q;
  assign done_out      = done_q;
  assign busy          = busy_q;
  assign cleared_cnt   = cnt_q;

endmodule
